// File: rtl/hub75_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : hub75_scan_driver
// Description : Row-scan engine for a 64x64 1/32-scan HUB75 panel. It asks a
//               combinational painter for pixels and shifts the upper and
//               lower halves out in parallel.
// Revision    : 1.0 - initial release
// ============================================================================
module hub75_scan_driver #(
    parameter int WIDTH      = 64,
    parameter int ROW_BITS   = 5,
    parameter int ON_CYCLES  = 0,
    parameter int SUBFRAMES  = 1,
    parameter int FRAME_BITS = 8,
    localparam int COL_W     = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int SF_W      = (SUBFRAMES > 1) ? $clog2(SUBFRAMES) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    output logic [COL_W-1:0]      px,
    output logic [ROW_BITS-1:0]   prow,
    output logic [SF_W-1:0]       psubframe,
    output logic [FRAME_BITS-1:0] pframe,
    input  logic [2:0]            pix_rgb0,
    input  logic [2:0]            pix_rgb1,
    output logic [2:0]            RGB0,
    output logic [2:0]            RGB1,
    output logic [ROW_BITS-1:0]   ADDR,
    output logic                  BLANK,
    output logic                  LATCH,
    output logic                  SCLK,
    output logic                  frame_tick
);

    localparam int ON_W = (ON_CYCLES > 1) ? $clog2(ON_CYCLES) : 1;

    localparam logic [1:0] c_st_shift   = 2'd0;
    localparam logic [1:0] c_st_blnk    = 2'd1;
    localparam logic [1:0] c_st_latch   = 2'd2;
    localparam logic [1:0] c_st_display = 2'd3;

    localparam logic [COL_W-1:0]    c_col_last = COL_W'(WIDTH - 1);
    localparam logic [ROW_BITS-1:0] c_row_last = '1;
    localparam logic [SF_W-1:0]     c_sf_last  = SF_W'(SUBFRAMES - 1);
    localparam logic [ON_W-1:0]     c_on_last  = ON_W'((ON_CYCLES > 0) ? ON_CYCLES - 1 : 0);

    logic [1:0]            r_state,     w_state;
    logic [COL_W-1:0]      r_col,       w_col;
    logic                  r_phase,     w_phase;
    logic [ROW_BITS-1:0]   r_shift_row, w_shift_row;
    logic [SF_W-1:0]       r_subframe,  w_subframe;
    logic [FRAME_BITS-1:0] r_frame,     w_frame;
    logic                  r_first,     w_first;
    logic [ON_W-1:0]       r_on_cnt,    w_on_cnt;
    logic [2:0]            r_rgb0,      w_rgb0;
    logic [2:0]            r_rgb1,      w_rgb1;
    logic [ROW_BITS-1:0]   r_addr,      w_addr;
    logic                  r_blank,     w_blank;
    logic                  r_latch,     w_latch;
    logic                  r_sclk,      w_sclk;
    logic                  r_tick,      w_tick;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= c_st_shift;
            r_col       <= '0;
            r_phase     <= 1'b0;
            r_shift_row <= '0;
            r_subframe  <= '0;
            r_frame     <= '0;
            r_first     <= 1'b1;
            r_on_cnt    <= '0;
            r_rgb0      <= '0;
            r_rgb1      <= '0;
            r_addr      <= '0;
            r_blank     <= 1'b1;
            r_latch     <= 1'b0;
            r_sclk      <= 1'b0;
            r_tick      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_col       <= w_col;
            r_phase     <= w_phase;
            r_shift_row <= w_shift_row;
            r_subframe  <= w_subframe;
            r_frame     <= w_frame;
            r_first     <= w_first;
            r_on_cnt    <= w_on_cnt;
            r_rgb0      <= w_rgb0;
            r_rgb1      <= w_rgb1;
            r_addr      <= w_addr;
            r_blank     <= w_blank;
            r_latch     <= w_latch;
            r_sclk      <= w_sclk;
            r_tick      <= w_tick;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_col       = r_col;
        w_phase     = r_phase;
        w_shift_row = r_shift_row;
        w_subframe  = r_subframe;
        w_frame     = r_frame;
        w_first     = r_first;
        w_on_cnt    = r_on_cnt;
        w_rgb0      = r_rgb0;
        w_rgb1      = r_rgb1;
        w_addr      = r_addr;
        w_blank     = r_blank;
        w_latch     = 1'b0;
        w_sclk      = r_sclk;
        w_tick      = 1'b0;

        case (r_state)
            c_st_shift: begin
                if (!r_phase) begin
                    // Data changes together with the SCLK falling edge.
                    w_rgb0  = pix_rgb0;
                    w_rgb1  = pix_rgb1;
                    w_sclk  = 1'b0;
                    w_phase = 1'b1;
                    w_blank = r_first;
                end else begin
                    w_sclk  = 1'b1;
                    w_phase = 1'b0;
                    if (r_col == c_col_last) begin
                        // Last rising edge coincides with blanking the old row.
                        w_col   = '0;
                        w_blank = 1'b1;
                        w_state = c_st_blnk;
                    end else begin
                        w_col = r_col + 1'b1;
                    end
                end
            end
            c_st_blnk: begin
                w_sclk  = 1'b0;
                w_blank = 1'b1;
                w_latch = 1'b1;
                w_addr  = r_shift_row;
                w_state = c_st_latch;
            end
            c_st_latch: begin
                w_blank     = 1'b0;
                w_first     = 1'b0;
                w_shift_row = r_shift_row + 1'b1;
                w_on_cnt    = '0;
                if (r_shift_row == c_row_last) begin
                    if (r_subframe == c_sf_last) begin
                        w_subframe = '0;
                        w_frame    = r_frame + 1'b1;
                        w_tick     = 1'b1;
                    end else begin
                        w_subframe = r_subframe + 1'b1;
                    end
                end
                w_state = (ON_CYCLES > 0) ? c_st_display : c_st_shift;
            end
            default: begin
                w_sclk  = 1'b0;
                w_blank = 1'b0;
                if (r_on_cnt == c_on_last) begin
                    w_state = c_st_shift;
                end else begin
                    w_on_cnt = r_on_cnt + 1'b1;
                end
            end
        endcase
    end

    assign px         = r_col;
    assign prow       = r_shift_row;
    assign psubframe  = r_subframe;
    assign pframe     = r_frame;
    assign RGB0       = r_rgb0;
    assign RGB1       = r_rgb1;
    assign ADDR       = r_addr;
    assign BLANK      = r_blank;
    assign LATCH      = r_latch;
    assign SCLK       = r_sclk;
    assign frame_tick = r_tick;

endmodule
`default_nettype wire

// File: tb/tb_hub75_scan_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_hub75_scan_driver
// Description : Directed bench: vector table for the default build, long scan
//               checks for an ON_CYCLES=4 / SUBFRAMES=2 / FRAME_BITS=2 build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hub75_scan_driver;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    // Build A: default parameters
    logic [5:0] a_px;
    logic [4:0] a_prow, a_addr;
    logic [0:0] a_psf;
    logic [7:0] a_pframe;
    logic [2:0] a_pix0, a_pix1, a_rgb0, a_rgb1;
    logic       a_blank, a_latch, a_sclk, a_tick;

    assign a_pix0 = {a_px[0], 2'b00};
    assign a_pix1 = 3'b010;

    hub75_scan_driver u_dut_a (
        .clk(clk), .reset(reset), .px(a_px), .prow(a_prow), .psubframe(a_psf),
        .pframe(a_pframe), .pix_rgb0(a_pix0), .pix_rgb1(a_pix1), .RGB0(a_rgb0),
        .RGB1(a_rgb1), .ADDR(a_addr), .BLANK(a_blank), .LATCH(a_latch),
        .SCLK(a_sclk), .frame_tick(a_tick)
    );

    // Build B: display stretch, two subframes, 2-bit frame counter
    logic [5:0] b_px;
    logic [4:0] b_prow, b_addr;
    logic [0:0] b_psf;
    logic [1:0] b_pframe;
    logic [2:0] b_pix0, b_pix1, b_rgb0, b_rgb1;
    logic       b_blank, b_latch, b_sclk, b_tick;

    assign b_pix0 = {b_prow[0], b_px[1], 1'b1};
    assign b_pix1 = {2'b00, b_px[0]};

    hub75_scan_driver #(.ON_CYCLES(4), .SUBFRAMES(2), .FRAME_BITS(2)) u_dut_b (
        .clk(clk), .reset(reset), .px(b_px), .prow(b_prow), .psubframe(b_psf),
        .pframe(b_pframe), .pix_rgb0(b_pix0), .pix_rgb1(b_pix1), .RGB0(b_rgb0),
        .RGB1(b_rgb1), .ADDR(b_addr), .BLANK(b_blank), .LATCH(b_latch),
        .SCLK(b_sclk), .frame_tick(b_tick)
    );

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         k;
        logic       blank, sclk, latch;
        logic [4:0] addr;
        logic [2:0] rgb0, rgb1;
        logic [5:0] px;
        logic [4:0] prow;
        logic [7:0] frame;
        logic       tick;
    } vec_t;

    vec_t tbl[17];

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    initial begin
        // k = rising edges since reset release; sampled on the falling edge
        //        k     blank sclk  latch addr rgb0 rgb1 px  prow frame tick
        tbl[0]  = '{0,    1'b1, 1'b0, 1'b0, 5'd0,  3'd0, 3'd0, 6'd0,  5'd0,  8'd0, 1'b0};
        tbl[1]  = '{1,    1'b1, 1'b0, 1'b0, 5'd0,  3'd0, 3'd2, 6'd0,  5'd0,  8'd0, 1'b0};
        tbl[2]  = '{2,    1'b1, 1'b1, 1'b0, 5'd0,  3'd0, 3'd2, 6'd1,  5'd0,  8'd0, 1'b0};
        tbl[3]  = '{3,    1'b1, 1'b0, 1'b0, 5'd0,  3'd4, 3'd2, 6'd1,  5'd0,  8'd0, 1'b0};
        tbl[4]  = '{4,    1'b1, 1'b1, 1'b0, 5'd0,  3'd4, 3'd2, 6'd2,  5'd0,  8'd0, 1'b0};
        tbl[5]  = '{5,    1'b1, 1'b0, 1'b0, 5'd0,  3'd0, 3'd2, 6'd2,  5'd0,  8'd0, 1'b0};
        tbl[6]  = '{127,  1'b1, 1'b0, 1'b0, 5'd0,  3'd4, 3'd2, 6'd63, 5'd0,  8'd0, 1'b0};
        tbl[7]  = '{128,  1'b1, 1'b1, 1'b0, 5'd0,  3'd4, 3'd2, 6'd0,  5'd0,  8'd0, 1'b0};
        tbl[8]  = '{129,  1'b1, 1'b0, 1'b1, 5'd0,  3'd4, 3'd2, 6'd0,  5'd0,  8'd0, 1'b0};
        tbl[9]  = '{130,  1'b0, 1'b0, 1'b0, 5'd0,  3'd4, 3'd2, 6'd0,  5'd1,  8'd0, 1'b0};
        tbl[10] = '{131,  1'b0, 1'b0, 1'b0, 5'd0,  3'd0, 3'd2, 6'd0,  5'd1,  8'd0, 1'b0};
        tbl[11] = '{132,  1'b0, 1'b1, 1'b0, 5'd0,  3'd0, 3'd2, 6'd1,  5'd1,  8'd0, 1'b0};
        tbl[12] = '{259,  1'b1, 1'b0, 1'b1, 5'd1,  3'd4, 3'd2, 6'd0,  5'd1,  8'd0, 1'b0};
        tbl[13] = '{260,  1'b0, 1'b0, 1'b0, 5'd1,  3'd4, 3'd2, 6'd0,  5'd2,  8'd0, 1'b0};
        tbl[14] = '{4159, 1'b1, 1'b0, 1'b1, 5'd31, 3'd4, 3'd2, 6'd0,  5'd31, 8'd0, 1'b0};
        tbl[15] = '{4160, 1'b0, 1'b0, 1'b0, 5'd31, 3'd4, 3'd2, 6'd0,  5'd0,  8'd1, 1'b1};
        tbl[16] = '{4161, 1'b0, 1'b0, 1'b0, 5'd31, 3'd0, 3'd2, 6'd0,  5'd0,  8'd1, 1'b0};

        // Mid-row asynchronous reset
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 301; i++) step();
        chk("pre-reset px", int'(a_px), 20);
        chk("pre-reset prow", int'(a_prow), 2);
        chk("pre-reset addr", int'(a_addr), 1);
        chk("pre-reset blank", int'(a_blank), 0);
        #2 reset = 1'b1;
        #1;
        chk("async blank", int'(a_blank), 1);
        chk("async sclk", int'(a_sclk), 0);
        chk("async latch", int'(a_latch), 0);
        chk("async addr", int'(a_addr), 0);
        chk("async rgb", int'({a_rgb0, a_rgb1}), 0);
        chk("async px", int'(a_px), 0);
        @(negedge clk);
        reset = 1'b0;

        // Vector table on build A, counting edges from this release
        begin
            int cur = 0;
            for (int i = 0; i < 17; i++) begin
                logic [33:0] act, exp;
                while (cur < tbl[i].k) begin
                    step();
                    cur++;
                end
                act = {a_blank, a_sclk, a_latch, a_addr, a_rgb0, a_rgb1, a_px, a_prow, a_pframe, a_tick};
                exp = {tbl[i].blank, tbl[i].sclk, tbl[i].latch, tbl[i].addr, tbl[i].rgb0,
                       tbl[i].rgb1, tbl[i].px, tbl[i].prow, tbl[i].frame, tbl[i].tick};
                n_vec++;
                if (act !== exp) begin
                    n_bad++;
                    $display("FAIL vec k=%0d: got blank=%0b sclk=%0b latch=%0b addr=%0d rgb0=%0d rgb1=%0d px=%0d prow=%0d frame=%0d tick=%0b, expected blank=%0b sclk=%0b latch=%0b addr=%0d rgb0=%0d rgb1=%0d px=%0d prow=%0d frame=%0d tick=%0b",
                             tbl[i].k, a_blank, a_sclk, a_latch, a_addr, a_rgb0, a_rgb1, a_px, a_prow, a_pframe, a_tick,
                             tbl[i].blank, tbl[i].sclk, tbl[i].latch, tbl[i].addr, tbl[i].rgb0, tbl[i].rgb1,
                             tbl[i].px, tbl[i].prow, tbl[i].frame, tbl[i].tick);
                end
            end
        end

        // Build B: four full frames of 64 rows, row period 2*64+2+4 cycles
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        begin
            int         n_lat = 0;
            int         last_lat = 0;
            int         blank_cnt = 0;
            int         ticks = 0;
            bit         early_lit = 1'b0;
            bit         after_lat = 1'b0;
            logic [4:0] exp_row = 5'd0;
            for (int k = 1; k <= 34305; k++) begin
                step();
                if (b_blank) blank_cnt++;
                if (n_lat == 0 && !b_blank) early_lit = 1'b1;
                if (b_latch) begin
                    if (n_lat == 0) begin
                        chk("B first latch cycle", k, 129);
                        chk("B lit before first latch", int'(early_lit), 0);
                    end else begin
                        chk("B row period", k - last_lat, 134);
                        chk("B blank cycles per row", blank_cnt, 2);
                    end
                    chk("B addr", int'(b_addr), int'(exp_row));
                    chk("B psubframe", int'(b_psf), (n_lat / 32) % 2);
                    chk("B pframe at latch", int'(b_pframe), (n_lat / 64) % 4);
                    last_lat  = k;
                    blank_cnt = 0;
                    exp_row   = exp_row + 5'd1;
                    n_lat++;
                    after_lat = 1'b1;
                end else if (after_lat) begin
                    chk("B post-latch blank/latch/sclk", int'({b_blank, b_latch, b_sclk}), 0);
                    after_lat = 1'b0;
                end
                if (b_tick) begin
                    ticks++;
                    chk("B tick follows latch", k - last_lat, 1);
                    chk("B tick on frame boundary", n_lat % 64, 0);
                    chk("B pframe at tick", int'(b_pframe), (n_lat / 64) % 4);
                end
            end
            chk("B latch count", n_lat, 256);
            chk("B frame ticks", ticks, 4);
            chk("B pframe wrapped", int'(b_pframe), 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
